// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART flow-control slice.
//   tx_state_e   : TX sequencer state encoding (IDLE, POP, LOAD, START, WAIT, GAP)
//   CNT_SAT_ALL  : all-ones source for the saturation value of the error
//                  counters. A counter of width N saturates at CNT_SAT_ALL[N-1:0].
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_GAP   = 3'd5
    } tx_state_e;

    localparam logic [31:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/uart_sat_cnt.sv
// -----------------------------------------------------------------------------
// uart_sat_cnt
// Saturating up-counter with synchronous clear. Clear wins over a same-cycle
// increment; once the count reaches all-ones further increments are ignored.
// Ports:
//   clk  in      rising-edge clock
//   rst  in      asynchronous active-high reset (count -> 0)
//   clr  in      synchronous clear
//   inc  in      increment request
//   cnt  out WD  current count
// -----------------------------------------------------------------------------
module uart_sat_cnt
    import uart_pkg::*;
#(
    parameter int WD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [WD-1:0] cnt
);

    localparam logic [WD-1:0] SAT_MAX = CNT_SAT_ALL[WD-1:0];

    logic [WD-1:0] cnt_d;
    logic [WD-1:0] cnt_q;

    always_comb begin
        // NOTE: the default assignment first means every path assigns cnt_d,
        // so no latch is inferred when neither branch below is taken.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != SAT_MAX)) begin
            cnt_d = cnt_q + WD'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order between blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_flow_ctrl.sv
// -----------------------------------------------------------------------------
// uart_flow_ctrl
// Sequencer between the host FIFOs and uart_top. Drains the TX FIFO one frame
// at a time, arms the receiver, commits clean received frames to the RX FIFO
// and counts frames with errors or that were dropped because the FIFO was full.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   tx_en               allow TX draining
//   rx_en               allow reception (registered onto rx_start)
//   cnt_clr             synchronous clear of all counters
//   tx_empty, tx_busy   TX FIFO empty / transmitter busy
//   tx_done             frame transmitted (pulse)
//   rx_full             RX FIFO full
//   rx_done             frame received (pulse), qualifies the error flags
//   framing_error_flag, parity_error_flag
//   tx_rd_en, tx_start  TX FIFO pop / transmitter start (pulses)
//   rx_start            receiver enable
//   rx_wr_en            RX FIFO push (pulse)
//   tx_active           TX sequencer busy with a frame (not IDLE)
//   frame_err_cnt, parity_err_cnt, overrun_cnt   saturating counters
// -----------------------------------------------------------------------------
module uart_flow_ctrl
    import uart_pkg::*;
#(
    parameter int TX_GAP      = 4,
    parameter int CNT_WD      = 8,
    parameter bit DROP_ON_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              rx_en,
    input  logic              cnt_clr,
    input  logic              tx_empty,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic              rx_full,
    input  logic              rx_done,
    input  logic              framing_error_flag,
    input  logic              parity_error_flag,
    output logic              tx_rd_en,
    output logic              tx_start,
    output logic              rx_start,
    output logic              rx_wr_en,
    output logic              tx_active,
    output logic [CNT_WD-1:0] frame_err_cnt,
    output logic [CNT_WD-1:0] parity_err_cnt,
    output logic [CNT_WD-1:0] overrun_cnt
);

    // The gap counter is loaded with TX_GAP-1 and counts down to 0, giving
    // exactly TX_GAP cycles in GAP. With TX_GAP=0 the GAP state is skipped.
    localparam int GAP_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (TX_GAP > 0) ? GAP_W'(TX_GAP - 1) : '0;

    tx_state_e        state_d, state_q;
    logic [GAP_W-1:0] gap_cnt_d, gap_cnt_q;
    logic             rx_start_d, rx_start_q;
    logic             rx_wr_en_d, rx_wr_en_q;

    logic rx_take;
    logic rx_err;
    logic fe_inc, pe_inc, ov_inc;

    // ---------------- TX sequencer ----------------
    // tx_en is only consulted in IDLE, so a frame already popped always runs
    // through WAIT and GAP even if tx_en drops mid-frame.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            ST_IDLE:  if (tx_en && !tx_empty && !tx_busy) state_d = ST_POP;
            ST_POP:   state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_START;   // FIFO rd_data is registered; let it settle
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    if (TX_GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d = ST_IDLE;
                else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign tx_rd_en  = (state_q == ST_POP);
    assign tx_start  = (state_q == ST_START);
    assign tx_active = (state_q != ST_IDLE);

    // ---------------- RX commit ----------------
    // Errors take priority over the full check: an errored frame never counts
    // as an overrun, and is pushed only when errors are tolerated and there is room.
    always_comb begin
        rx_start_d = rx_en;
        rx_take    = rx_done & rx_en;
        rx_err     = framing_error_flag | parity_error_flag;
        fe_inc     = rx_take & framing_error_flag;
        pe_inc     = rx_take & parity_error_flag;
        ov_inc     = rx_take & ~rx_err & rx_full;
        rx_wr_en_d = rx_take & ~rx_full & (~rx_err | ~DROP_ON_ERR);
    end

    assign rx_start = rx_start_q;
    assign rx_wr_en = rx_wr_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= '0;
            rx_start_q <= 1'b0;
            rx_wr_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            rx_start_q <= rx_start_d;
            rx_wr_en_q <= rx_wr_en_d;
        end
    end

    // ---------------- Error counters ----------------
    uart_sat_cnt #(.WD(CNT_WD)) u_frame_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (fe_inc),
        .cnt (frame_err_cnt)
    );

    uart_sat_cnt #(.WD(CNT_WD)) u_parity_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (pe_inc),
        .cnt (parity_err_cnt)
    );

    uart_sat_cnt #(.WD(CNT_WD)) u_overrun_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (ov_inc),
        .cnt (overrun_cnt)
    );

endmodule

// File: tb/tb_uart_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_flow_ctrl
// Directed and randomized bench for uart_flow_ctrl. A small behavioural stand-in
// for uart_top (FIFO occupancy as pushed/popped counts, a transmitter that stays
// busy for TX_LEN cycles) drives the status flags. Event cycles are logged on the
// falling edge and compared against the timing rules; RX behaviour is compared
// against an arithmetic model of the counters and pushes.
// -----------------------------------------------------------------------------
module tb_uart_flow_ctrl;

    localparam int TX_GAP = 4;
    localparam int CNT_WD = 8;
    localparam int TX_LEN = 5;
    localparam int SAT    = (1 << CNT_WD) - 1;

    logic clk = 1'b0;
    logic rst;
    logic tx_en, rx_en, cnt_clr;
    logic tx_empty, tx_busy, tx_done;
    logic rx_full, rx_done, framing_error_flag, parity_error_flag;
    logic tx_rd_en, tx_start, rx_start, rx_wr_en, tx_active;
    logic [CNT_WD-1:0] frame_err_cnt, parity_err_cnt, overrun_cnt;

    uart_flow_ctrl #(
        .TX_GAP      (TX_GAP),
        .CNT_WD      (CNT_WD),
        .DROP_ON_ERR (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_en              (tx_en),
        .rx_en              (rx_en),
        .cnt_clr            (cnt_clr),
        .tx_empty           (tx_empty),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .rx_full            (rx_full),
        .rx_done            (rx_done),
        .framing_error_flag (framing_error_flag),
        .parity_error_flag  (parity_error_flag),
        .tx_rd_en           (tx_rd_en),
        .tx_start           (tx_start),
        .rx_start           (rx_start),
        .rx_wr_en           (rx_wr_en),
        .tx_active          (tx_active),
        .frame_err_cnt      (frame_err_cnt),
        .parity_err_cnt     (parity_err_cnt),
        .overrun_cnt        (overrun_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // uart_top stand-in state
    int queued   = 0;
    int popped   = 0;
    int busy_cnt = 0;

    // event logs (cycle numbers)
    int rd_q[$];
    int st_q[$];
    int done_q[$];
    int wr_q[$];
    int act_last = -1;

    // RX reference model
    int m_fe = 0, m_pe = 0, m_ov = 0, m_push = 0;
    logic m_last_push = 1'b0;

    assign tx_empty = (queued == popped);

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and transmitter model, evaluated mid-cycle.
    always @(negedge clk) begin
        if (tx_rd_en) begin
            rd_q.push_back(cyc);
            popped = popped + 1;
        end
        if (tx_start)  st_q.push_back(cyc);
        if (rx_wr_en)  wr_q.push_back(cyc);
        if (tx_active) act_last = cyc;
        tx_done = 1'b0;
        if (tx_start) begin
            busy_cnt = TX_LEN;
            tx_busy  = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) begin
                tx_busy = 1'b0;
                tx_done = 1'b1;
                done_q.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int v, input logic inc);
        return (inc && v < SAT) ? v + 1 : v;
    endfunction

    // Drive one cycle of RX inputs and advance the reference model.
    task automatic drive_rx(input logic done, input logic f, input logic p,
                            input logic full, input logic en, input logic clr);
        rx_done = done; framing_error_flag = f; parity_error_flag = p;
        rx_full = full; rx_en = en; cnt_clr = clr;
        m_last_push = done && en && !f && !p && !full;
        if (clr) begin
            m_fe = 0; m_pe = 0; m_ov = 0;
        end else if (done && en) begin
            if (f || p) begin
                m_fe = sat_inc(m_fe, f);
                m_pe = sat_inc(m_pe, p);
            end else begin
                m_ov = sat_inc(m_ov, full);
            end
        end
        if (m_last_push) m_push++;
        step();
        rx_done = 1'b0; framing_error_flag = 1'b0; parity_error_flag = 1'b0;
        cnt_clr = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        tx_en = 0; rx_en = 0; cnt_clr = 0; tx_busy = 0; tx_done = 0;
        rx_full = 0; rx_done = 0; framing_error_flag = 0; parity_error_flag = 0;

        // ---------------- reset values ----------------
        step(); step();
        check("rst_tx_rd_en",  tx_rd_en,  0);
        check("rst_tx_start",  tx_start,  0);
        check("rst_rx_start",  rx_start,  0);
        check("rst_rx_wr_en",  rx_wr_en,  0);
        check("rst_tx_active", tx_active, 0);
        check("rst_fe_cnt",    frame_err_cnt,  0);
        check("rst_pe_cnt",    parity_err_cnt, 0);
        check("rst_ov_cnt",    overrun_cnt,    0);
        rst = 1'b0;
        step();

        // ---------------- 3 frames back to back ----------------
        tx_en = 1'b1;
        step();
        k = cyc;
        queued += 3;
        for (int i = 0; i < 300 && !(done_q.size() == 3 && !tx_active); i++) step();
        check("tx3_pops",   rd_q.size(),   3);
        check("tx3_starts", st_q.size(),   3);
        check("tx3_dones",  done_q.size(), 3);
        check("tx3_first_pop", (rd_q.size() > 0) ? rd_q[0] : -1, k + 1);
        for (int i = 0; i < rd_q.size() && i < st_q.size(); i++)
            check("tx3_start_lag", st_q[i] - rd_q[i], 2);
        for (int i = 0; i + 1 < rd_q.size() && i < done_q.size(); i++)
            check("tx3_done_to_pop", rd_q[i + 1] - done_q[i], TX_GAP + 2);

        // ---------------- tx_en dropped mid-frame ----------------
        rd_q.delete(); st_q.delete(); done_q.delete();
        step();
        queued += 2;
        for (int i = 0; i < 50 && st_q.size() < 1; i++) step();
        step(); step();
        check("drop_in_wait", tx_active, 1);
        tx_en = 1'b0;
        for (int i = 0; i < 50 && !(done_q.size() == 1 && !tx_active); i++) step();
        repeat (20) step();
        check("drop_pops",   rd_q.size(),   1);
        check("drop_starts", st_q.size(),   1);
        check("drop_idle",   tx_active,     0);
        check("drop_gap_len", act_last, (done_q.size() > 0) ? done_q[0] + TX_GAP : -1);

        // ---------------- reset during LOAD ----------------
        rd_q.delete(); st_q.delete(); done_q.delete();
        tx_en = 1'b1;
        for (int i = 0; i < 10 && rd_q.size() < 1; i++) step();
        step();   // now in LOAD
        check("load_active", tx_active, 1);
        rst = 1'b1;
        #1;
        check("arst_tx_rd_en",  tx_rd_en,  0);
        check("arst_tx_start",  tx_start,  0);
        check("arst_tx_active", tx_active, 0);
        check("arst_rx_wr_en",  rx_wr_en,  0);
        tx_en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("arst_no_start", st_q.size(), 0);
        tx_en = 1'b1;
        k = cyc;
        queued += 1;
        for (int i = 0; i < 100 && !(done_q.size() == 1 && !tx_active); i++) step();
        check("post_rst_pops", rd_q.size(), 2);
        check("post_rst_pop_time", (rd_q.size() > 1) ? rd_q[1] : -1, k + 1);
        check("post_rst_starts", st_q.size(), 1);
        check("post_rst_start_lag",
              (rd_q.size() > 1 && st_q.size() > 0) ? st_q[0] - rd_q[1] : -1, 2);
        tx_en = 1'b0;

        // ---------------- rx_start follows rx_en ----------------
        step();
        rx_en = 1'b1;
        check("rx_start_lag0", rx_start, 0);
        step();
        check("rx_start_lag1", rx_start, 1);

        // ---------------- clean frame ----------------
        wr_q.delete();
        k = cyc;
        drive_rx(1, 0, 0, 0, 1, 0);
        check("clean_wr_pulse", rx_wr_en, 1);
        step();
        check("clean_wr_once", rx_wr_en, 0);
        check("clean_wr_time", (wr_q.size() > 0) ? wr_q[0] : -1, k + 1);
        check("clean_fe", frame_err_cnt,  0);
        check("clean_pe", parity_err_cnt, 0);
        check("clean_ov", overrun_cnt,    0);

        // ---------------- both errors, then saturation ----------------
        wr_q.delete();
        drive_rx(1, 1, 1, 0, 1, 0);
        check("err_no_push", rx_wr_en, 0);
        check("err_fe", frame_err_cnt,  1);
        check("err_pe", parity_err_cnt, 1);
        for (int i = 0; i < 300; i++) drive_rx(1, 1, 0, 0, 1, 0);
        check("sat_fe", frame_err_cnt,  255);
        check("sat_pe", parity_err_cnt, 1);
        check("sat_no_push", wr_q.size(), 0);

        // ---------------- overrun, then clear vs increment ----------------
        drive_rx(1, 0, 0, 1, 1, 0);
        check("ovr_cnt", overrun_cnt, 1);
        check("ovr_no_push", rx_wr_en, 0);
        drive_rx(1, 0, 0, 1, 1, 1);
        check("clr_ov", overrun_cnt,    0);
        check("clr_fe", frame_err_cnt,  0);
        check("clr_pe", parity_err_cnt, 0);

        // ---------------- rx_done ignored when rx_en=0 ----------------
        drive_rx(1, 0, 0, 0, 0, 0);
        check("dis_no_push", rx_wr_en, 0);
        drive_rx(1, 1, 1, 0, 0, 0);
        check("dis_fe", frame_err_cnt,  0);
        check("dis_pe", parity_err_cnt, 0);

        // ---------------- randomized RX traffic ----------------
        wr_q.delete();
        m_push = 0;
        for (int i = 0; i < 400; i++) begin
            drive_rx(logic'($urandom_range(0, 1)),
                     logic'($urandom_range(0, 3) == 0),
                     logic'($urandom_range(0, 3) == 0),
                     logic'($urandom_range(0, 3) == 0),
                     logic'($urandom_range(0, 7) != 0),
                     logic'($urandom_range(0, 63) == 0));
            check("rnd_wr_en", rx_wr_en,       m_last_push);
            check("rnd_fe",    frame_err_cnt,  m_fe);
            check("rnd_pe",    parity_err_cnt, m_pe);
            check("rnd_ov",    overrun_cnt,    m_ov);
        end
        rx_en = 1'b1;
        step();
        check("rnd_push_total", wr_q.size(), m_push);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_flow_ctrl.md
# uart_flow_ctrl

Autonomous sequencer between the host side and `uart_top`. It drains the TX FIFO one frame at a time by driving `tx_rd_en` and `tx_start`, and arms the receiver through `rx_start`. It commits clean received frames into the RX FIFO with `rx_wr_en` and drops frames that have errors or arrive while the FIFO is full, counting each dropped frame. Its outputs connect directly to the `uart_top` enable inputs, and its inputs are the `uart_top` status flags.

## Interface
Parameters:
- `TX_GAP`, default 4: idle clk cycles inserted after `tx_done` before the next FIFO pop (0 allowed).
- `CNT_WD`, default 8: width of the saturating error counters.
- `DROP_ON_ERR`, default 1: 1 drops frames flagged with framing/parity errors; 0 commits them anyway (still counted).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_en`  in  1  allow TX draining.
- `rx_en`  in  1  allow reception; drives `rx_start`.
- `cnt_clr`  in  1  synchronous clear of all counters.
- `tx_empty`  in  1  TX FIFO empty.
- `tx_busy`  in  1  transmitter busy.
- `tx_done`  in  1  frame transmitted (1-cycle pulse).
- `rx_full`  in  1  RX FIFO full.
- `rx_done`  in  1  frame received (1-cycle pulse).
- `framing_error_flag`  in  1  framing error, valid with `rx_done`.
- `parity_error_flag`  in  1  parity error, valid with `rx_done`.
- `tx_rd_en`  out  1  TX FIFO pop (1-cycle pulse).
- `tx_start`  out  1  transmitter start (1-cycle pulse).
- `rx_start`  out  1  receiver enable.
- `rx_wr_en`  out  1  RX FIFO push (1-cycle pulse).
- `tx_active`  out  1  TX FSM not in IDLE.
- `frame_err_cnt`  out  CNT_WD  framing-error frames.
- `parity_err_cnt`  out  CNT_WD  parity-error frames.
- `overrun_cnt`  out  CNT_WD  clean frames dropped because `rx_full` was high.

## Operation
- TX FSM states are IDLE, POP, LOAD, START, WAIT, GAP.
  - IDLE → POP when `tx_en & !tx_empty & !tx_busy`.
  - POP asserts `tx_rd_en`, then → LOAD. LOAD lets the registered FIFO `rd_data` settle, then → START.
  - START asserts `tx_start`, then → WAIT.
  - WAIT holds until `tx_done`, then → GAP, or → IDLE directly if `TX_GAP`=0.
  - GAP counts `TX_GAP` cycles, then → IDLE.
- If `tx_en` falls mid-frame, the FSM completes the current frame through GAP, then stays in IDLE.
- `rx_start` = `rx_en` registered. The receiver is enabled one cycle after `rx_en` rises.
- RX commit on `rx_done`, evaluated in this priority order:
  - Error present (`framing_error_flag | parity_error_flag`): increment each flagged counter (both if both are set). If `DROP_ON_ERR`=0 and `!rx_full`, also push the frame.
  - Otherwise `rx_full`: increment `overrun_cnt`, no push.
  - Otherwise: `rx_wr_en` pulse.
- Counters saturate at all-ones. `cnt_clr` has priority over a same-cycle increment; the result is 0.
- `rx_done` while `rx_en`=0 is ignored: no push, no count.

## Timing
- Reset values: all pulses 0, `rx_start` 0, `tx_active` 0, counters 0, TX FSM in IDLE.
- Reset mid-operation returns everything to reset values immediately. It does not wait for frame completion.
- `tx_rd_en` is asserted 1 cycle after the IDLE qualifying condition is sampled. `tx_start` follows `tx_rd_en` by exactly 2 cycles.
- From `tx_done` to the next `tx_rd_en` is `TX_GAP`+2 cycles when the FIFO is non-empty.
- `rx_wr_en` is asserted exactly 1 cycle after `rx_done`. Counter updates are visible 1 cycle after `rx_done`.
- `tx_rd_en` is never asserted while `tx_empty` is 1 in the same cycle it is evaluated. At most one pop per frame.

## Structure
- A shared package `uart_pkg` holds the TX state encoding and the localparam for the counter saturation value.
- Natural sub-module: `uart_sat_cnt` (saturating counter with increment and clear), instantiated three times.
- The TX FSM and the RX commit logic live in the top of this block.

## Test plan
- 3 bytes queued, `tx_en`=1, `TX_GAP`=4: exactly 3 `tx_rd_en`/`tx_start` pairs, each `tx_start` 2 cycles after its `tx_rd_en`, and 6 cycles from each `tx_done` to the next `tx_rd_en`.
- `tx_en` dropped during WAIT of frame 1 of 2: frame 1 completes, no second pop, `tx_active`=0 after GAP.
- Clean `rx_done` with `rx_full`=0: `rx_wr_en` pulses 1 cycle later, and all counters stay 0.
- `rx_done` with both error flags and `DROP_ON_ERR`=1: no push, `frame_err_cnt`=1 and `parity_err_cnt`=1. Then 300 more framing-error frames leave the counter saturated at 255.
- Clean `rx_done` with `rx_full`=1: `overrun_cnt`=1, no push. `cnt_clr` asserted in the same cycle as a later overrun leaves the counter at 0.
- `rst` asserted during LOAD: `tx_start` never pulses, all outputs return to 0 asynchronously, and the next frame starts cleanly from IDLE.
